// File: rtl/gpio_in_irq_slave.sv
// AXI4-Lite slave exposing synchronized GPIO inputs with per-pin edge-triggered
// interrupt pending bits, enable mask and rising/falling polarity select.
module gpio_in_irq_slave #(
   parameter int NUM_GPIO_IN = 16,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
   input  logic                   s_axi_awvalid,
   output logic                   s_axi_awready,
   input  logic [31:0]            s_axi_wdata,
   input  logic [3:0]             s_axi_wstrb,
   input  logic                   s_axi_wvalid,
   output logic                   s_axi_wready,
   output logic [1:0]             s_axi_bresp,
   output logic                   s_axi_bvalid,
   input  logic                   s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]  s_axi_araddr,
   input  logic                   s_axi_arvalid,
   output logic                   s_axi_arready,
   output logic [31:0]            s_axi_rdata,
   output logic [1:0]             s_axi_rresp,
   output logic                   s_axi_rvalid,
   input  logic                   s_axi_rready,
   input  logic [NUM_GPIO_IN-1:0] gpio_in_i,
   output logic                   int_o
);

   localparam logic [31:0] VALID_MASK = 32'hFFFF_FFFF >> (32 - NUM_GPIO_IN);
   localparam logic [1:0]  RESP_OKAY  = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   wstate_t wstate;
   rstate_t rstate;

   logic [NUM_GPIO_IN-1:0] sync1, sync2, prev;
   logic [1:0]  ramp;
   logic        ramp_done;
   logic [31:0] ier, isr, edge_sel;
   logic [31:0] sync2_w, prev_w, edge_evt, wmask, w1c;
   logic [5:0]  w_index, r_index;
   logic        wr_fire;
   logic [31:0] rd_value;
   logic [1:0]  rd_resp;

   function automatic logic [31:0] byte_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

   assign w_index       = s_axi_awaddr[7:2];
   assign r_index       = s_axi_araddr[7:2];
   assign s_axi_awready = (wstate == W_IDLE) && s_axi_awvalid && s_axi_wvalid && !reset_i;
   assign s_axi_wready  = s_axi_awready;
   assign wr_fire       = s_axi_awready;
   assign wmask         = byte_mask(s_axi_wstrb);
   assign w1c           = (wr_fire && w_index == 6'd2) ? (s_axi_wdata & wmask) : 32'h0;

   assign sync2_w   = 32'(sync2);
   assign prev_w    = 32'(prev);
   assign ramp_done = (ramp == 2'd2);
   assign edge_evt  = ramp_done ? (((sync2_w & ~prev_w & ~edge_sel) |
                                    (prev_w & ~sync2_w & edge_sel)) & VALID_MASK)
                                : 32'h0;

   // Until the synchronizer has filled, previous tracks stage 2 so pins already high are not events
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
         ramp  <= 2'd0;
      end else begin
         sync1 <= gpio_in_i;
         sync2 <= sync1;
         prev  <= ramp_done ? sync2 : sync1;
         if (!ramp_done) ramp <= ramp + 2'd1;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         ier      <= 32'h0;
         edge_sel <= 32'h0;
         isr      <= 32'h0;
         int_o    <= 1'b0;
      end else begin
         if (wr_fire && w_index == 6'd1)
            ier <= ((ier & ~wmask) | (s_axi_wdata & wmask)) & VALID_MASK;
         if (wr_fire && w_index == 6'd3)
            edge_sel <= ((edge_sel & ~wmask) | (s_axi_wdata & wmask)) & VALID_MASK;
         isr   <= (isr & ~w1c) | edge_evt;
         int_o <= |(isr & ier);
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         wstate       <= W_IDLE;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
      end else begin
         case (wstate)
            W_IDLE: if (wr_fire) begin
               s_axi_bvalid <= 1'b1;
               s_axi_bresp  <= (w_index >= 6'd4) ? RESP_SLVERR : RESP_OKAY;
               wstate       <= W_RESP;
            end
            W_RESP: if (s_axi_bready) begin
               s_axi_bvalid <= 1'b0;
               wstate       <= W_IDLE;
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_value = 32'h0;
      rd_resp  = RESP_OKAY;
      case (r_index)
         6'd0:    rd_value = sync2_w;
         6'd1:    rd_value = ier;
         6'd2:    rd_value = isr;
         6'd3:    rd_value = edge_sel;
         default: rd_resp  = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         rstate        <= R_IDLE;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rdata   <= 32'h0;
         s_axi_rresp   <= RESP_OKAY;
      end else begin
         case (rstate)
            R_IDLE: begin
               s_axi_arready <= 1'b1;
               if (s_axi_arvalid && s_axi_arready) begin
                  s_axi_arready <= 1'b0;
                  s_axi_rvalid  <= 1'b1;
                  s_axi_rdata   <= rd_value;
                  s_axi_rresp   <= rd_resp;
                  rstate        <= R_DATA;
               end
            end
            R_DATA: if (s_axi_rready) begin
               s_axi_rvalid  <= 1'b0;
               s_axi_arready <= 1'b1;
               rstate        <= R_IDLE;
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_in_irq_slave.sv
// Directed bench for gpio_in_irq_slave: register-access vector table followed by
// hand-written sequences for edge timing, W1C collision, AXI stalls and reset.
module tb_gpio_in_irq_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] awaddr = 32'h0, wdata = 32'h0, araddr = 32'h0, rdata;
   logic [3:0]  wstrb = 4'h0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid, irq;
   logic [1:0]  bresp, rresp;
   logic [15:0] gpio = 16'h0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   gpio_in_irq_slave #(.NUM_GPIO_IN(16), .ADDR_WIDTH(32)) dut (
      .clock_i(clk), .reset_i(rst),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .gpio_in_i(gpio), .int_o(irq)
   );

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs [22];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      int t;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      #1;
      t = 0;
      while (!awready && t < 20) begin @(negedge clk); t++; end
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      t = 0;
      while (!bvalid && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) chk("write_timeout", 64'd1, 64'd0);
      resp = bresp;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      int t;
      araddr = addr; arvalid = 1'b1;
      t = 0;
      while (!arready && t < 20) begin @(negedge clk); t++; end
      @(negedge clk);
      arvalid = 1'b0;
      t = 0;
      while (!rvalid && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) chk("read_timeout", 64'd1, 64'd0);
      data = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  rs;

      vecs[0]  = '{1'b0, 32'h00,  32'h0,         4'h0, 32'h0,      2'b00};
      vecs[1]  = '{1'b1, 32'h04,  32'hFFFF_FFFF, 4'hF, 32'h0,      2'b00};
      vecs[2]  = '{1'b0, 32'h04,  32'h0,         4'h0, 32'hFFFF,   2'b00};
      vecs[3]  = '{1'b1, 32'h04,  32'h1234_5678, 4'h1, 32'h0,      2'b00};
      vecs[4]  = '{1'b0, 32'h05,  32'h0,         4'h0, 32'hFF78,   2'b00};
      vecs[5]  = '{1'b1, 32'h04,  32'h0000_ABCD, 4'h2, 32'h0,      2'b00};
      vecs[6]  = '{1'b0, 32'h104, 32'h0,         4'h0, 32'hAB78,   2'b00};
      vecs[7]  = '{1'b1, 32'h0C,  32'h0000_F0F0, 4'hC, 32'h0,      2'b00};
      vecs[8]  = '{1'b0, 32'h0C,  32'h0,         4'h0, 32'h0,      2'b00};
      vecs[9]  = '{1'b1, 32'h0C,  32'h00FF_1234, 4'hF, 32'h0,      2'b00};
      vecs[10] = '{1'b0, 32'h0C,  32'h0,         4'h0, 32'h1234,   2'b00};
      vecs[11] = '{1'b1, 32'h00,  32'hFFFF,      4'hF, 32'h0,      2'b00};
      vecs[12] = '{1'b0, 32'h00,  32'h0,         4'h0, 32'h0,      2'b00};
      vecs[13] = '{1'b1, 32'h20,  32'hFFFF,      4'hF, 32'h0,      2'b10};
      vecs[14] = '{1'b0, 32'h20,  32'h0,         4'h0, 32'h0,      2'b10};
      vecs[15] = '{1'b0, 32'h10,  32'h0,         4'h0, 32'h0,      2'b10};
      vecs[16] = '{1'b0, 32'hFC,  32'h0,         4'h0, 32'h0,      2'b10};
      vecs[17] = '{1'b0, 32'h04,  32'h0,         4'h0, 32'hAB78,   2'b00};
      vecs[18] = '{1'b0, 32'h0C,  32'h0,         4'h0, 32'h1234,   2'b00};
      vecs[19] = '{1'b0, 32'h08,  32'h0,         4'h0, 32'h0,      2'b00};
      vecs[20] = '{1'b1, 32'h04,  32'h0,         4'hF, 32'h0,      2'b00};
      vecs[21] = '{1'b1, 32'h0C,  32'h0,         4'hF, 32'h0,      2'b00};

      // reset state
      cycles(2);
      chk("reset_outputs", {55'h0, irq, awready, wready, bvalid, arready, rvalid, bresp[0], rresp[0]}, 64'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("arready_after_release", {63'h0, arready}, 64'd1);
      cycles(3);

      for (int i = 0; i < 22; i++) begin
         if (vecs[i].wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
            chk($sformatf("vec%0d_wr", i), {62'h0, rs}, {62'h0, vecs[i].exp_resp});
         end else begin
            axi_read(vecs[i].addr, rd, rs);
            chk($sformatf("vec%0d_rd", i), {30'h0, rd, rs}, {30'h0, vecs[i].exp_data, vecs[i].exp_resp});
         end
      end

      // rising edge on pin 0 with IER bit 0 set
      axi_write(32'h04, 32'h1, 4'hF, rs);
      gpio[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("irq_low_edge%0d", i), {63'h0, irq}, 64'd0);
      end
      @(negedge clk);
      chk("irq_high_edge3", {63'h0, irq}, 64'd1);
      axi_read(32'h08, rd, rs);
      chk("isr_pin0", {32'h0, rd}, 64'h1);
      axi_read(32'h00, rd, rs);
      chk("data_pin0", {32'h0, rd}, 64'h1);
      axi_write(32'h08, 32'h1, 4'hF, rs);
      axi_read(32'h08, rd, rs);
      chk("isr_w1c", {32'h0, rd}, 64'h0);
      chk("irq_after_w1c", {63'h0, irq}, 64'd0);
      gpio[0] = 1'b0;
      cycles(5);
      axi_read(32'h08, rd, rs);
      chk("isr_no_fall_event", {32'h0, rd}, 64'h0);

      // falling polarity on pin 2, interrupt masked
      axi_write(32'h04, 32'h0, 4'hF, rs);
      axi_write(32'h0C, 32'h4, 4'hF, rs);
      gpio[2] = 1'b1;
      cycles(5);
      axi_read(32'h08, rd, rs);
      chk("isr_pin2_rise_ignored", {32'h0, rd}, 64'h0);
      gpio[2] = 1'b0;
      cycles(5);
      axi_read(32'h08, rd, rs);
      chk("isr_pin2_fall", {32'h0, rd}, 64'h4);
      chk("irq_masked", {63'h0, irq}, 64'd0);
      axi_write(32'h08, 32'h4, 4'hF, rs);
      axi_write(32'h0C, 32'h0, 4'hF, rs);

      // W1C on ISR[5] at the same edge a new rising event sets it
      gpio[5] = 1'b1;
      cycles(5);
      axi_read(32'h08, rd, rs);
      chk("isr_pin5_first", {32'h0, rd}, 64'h20);
      gpio[5] = 1'b0;
      cycles(5);
      gpio[5] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      awaddr = 32'h08; wdata = 32'h20; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("collision_bvalid", {63'h0, bvalid}, 64'd1);
      @(negedge clk);
      bready = 1'b0;
      axi_read(32'h08, rd, rs);
      chk("isr_set_wins", {32'h0, rd}, 64'h20);
      axi_write(32'h08, 32'h20, 4'hF, rs);
      gpio[5] = 1'b0;
      cycles(5);

      // AW two cycles ahead of W, bready stalled, concurrent read
      awaddr = 32'h04; awvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      chk("aw_only_0", {62'h0, awready, wready}, 64'd0);
      @(negedge clk);
      chk("aw_only_1", {62'h0, awready, wready}, 64'd0);
      wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
      #1;
      chk("aw_w_ready", {62'h0, awready, wready}, 64'd3);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("b_after_hs", {61'h0, bvalid, bresp}, {61'h0, 1'b1, 2'b00});
      @(negedge clk);
      chk("no_second_hs", {62'h0, awready, bvalid}, 64'd1);
      axi_read(32'h04, rd, rs);
      chk("concurrent_read", {30'h0, rd, rs}, {30'h0, 32'h55, 2'b00});
      chk("b_held", {61'h0, bvalid, bresp}, {61'h0, 1'b1, 2'b00});
      bready = 1'b1;
      @(negedge clk);
      chk("b_done", {63'h0, bvalid}, 64'd0);
      bready = 1'b0;
      axi_write(32'h04, 32'h0, 4'hF, rs);

      // asynchronous reset with B response pending and pins driven high
      axi_write(32'h04, 32'h1, 4'hF, rs);
      gpio[0] = 1'b1;
      cycles(5);
      chk("irq_before_reset", {63'h0, irq}, 64'd1);
      awaddr = 32'h0C; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("b_pending", {63'h0, bvalid}, 64'd1);
      gpio = 16'hFFFF;
      #2 rst = 1'b1;
      #1;
      chk("reset_async", {26'h0, irq, bvalid, arready, rvalid, awready, wready, bresp, rresp, rdata},
          64'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bready = 1'b1;
      @(negedge clk);
      chk("arready_first_edge", {62'h0, arready, bvalid}, 64'd2);
      cycles(4);
      chk("no_stale_b", {63'h0, bvalid}, 64'd0);
      bready = 1'b0;
      axi_read(32'h08, rd, rs);
      chk("isr_after_reset", {32'h0, rd}, 64'h0);
      axi_read(32'h04, rd, rs);
      chk("ier_after_reset", {32'h0, rd}, 64'h0);
      axi_read(32'h00, rd, rs);
      chk("data_after_reset", {32'h0, rd}, 64'hFFFF);
      chk("irq_after_reset", {63'h0, irq}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gpio_in_irq_slave.md
GPIO_IN_IRQ_SLAVE -- requirements
Module: gpio_in_irq_slave

Interface
REQ-001 SHALL have parameter NUM_GPIO_IN, default 16, number of GPIO input pins (1..32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-003 SHALL have port clock_i  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s_axi_awaddr input ADDR_WIDTH, s_axi_awvalid input 1, s_axi_awready output 1: write address channel.
REQ-006 SHALL have ports s_axi_wdata input 32, s_axi_wstrb input 4, s_axi_wvalid input 1, s_axi_wready output 1: write data channel.
REQ-007 SHALL have ports s_axi_bresp output 2, s_axi_bvalid output 1, s_axi_bready input 1: write response channel.
REQ-008 SHALL have ports s_axi_araddr input ADDR_WIDTH, s_axi_arvalid input 1, s_axi_arready output 1: read address channel.
REQ-009 SHALL have ports s_axi_rdata output 32, s_axi_rresp output 2, s_axi_rvalid output 1, s_axi_rready input 1: read data channel.
REQ-010 SHALL have port gpio_in_i  input  NUM_GPIO_IN  asynchronous external pins.
REQ-011 SHALL have port int_o  output  1  level interrupt toward the interrupt controller.

Function
REQ-012 Register map, index = addr[7:2]; addr[1:0] and bits above 7 ignored: 0 DATA (RO, synchronized pins), 1 IER (RW enable), 2 ISR (pending, read, write-1-to-clear), 3 EDGE (RW; bit=0 rising, 1 falling).
REQ-013 Index 4..63: read returns 0 with RRESP=SLVERR (2'b10); write has no effect, BRESP=SLVERR; mapped accesses respond OKAY (2'b00).
REQ-014 Register bits above NUM_GPIO_IN SHALL read 0 and ignore writes.
REQ-015 Writes to IER/EDGE/ISR SHALL honour WSTRB per byte lane; writes to DATA ignored, OKAY.
REQ-016 Write FSM states W_IDLE, W_RESP: in W_IDLE, awready=wready=1 for one cycle only when awvalid and wvalid both high; register updated on that edge; next state W_RESP.
REQ-017 W_RESP: bvalid=1, bresp held stable until bready; on bvalid&&bready return to W_IDLE; no new AW/W accepted while in W_RESP.
REQ-018 Read FSM states R_IDLE, R_DATA: arready=1 in R_IDLE; on arvalid capture rdata/rresp, go R_DATA; rvalid=1 and rdata stable until rready; then R_IDLE.
REQ-019 Read latency: rvalid asserted the cycle after AR handshake; write response bvalid the cycle after AW/W handshake.
REQ-020 Read and write channels SHALL operate independently and concurrently.
REQ-021 Each pin SHALL pass a 2-flop synchronizer, then a third "previous" flop; edge detected combinationally from sync stage 2 vs previous, polarity per EDGE bit.
REQ-022 Detected edge sets ISR bit on the same edge that loads the previous flop: pin change before edge N -> ISR bit set after edge N+2.
REQ-023 ISR set is independent of IER; IER masks only the interrupt.
REQ-024 Simultaneous edge event and W1C on same bit SHALL leave bit set (set wins).
REQ-025 int_o SHALL be registered: int_o = |(ISR & IER) one cycle after ISR/IER change.
REQ-026 EDGE change SHALL NOT itself create an event unless sync2 and previous differ in the new polarity.

Reset
REQ-027 Reset asserted SHALL immediately clear: IER, ISR, EDGE, all synchronizer flops, int_o=0, awready=wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rdata=0, rresp=0; FSMs to W_IDLE/R_IDLE.
REQ-028 Reset mid-transaction SHALL abort it; no response issued after release; arready=1 the first edge after release.
REQ-029 After release, a pin held high SHALL NOT generate a rising event (synchronizer ramp from 0 excluded: previous flop loads alongside stage 2 for the first 2 cycles).

Verification
REQ-030 Write IER=0x0001, then rising edge on gpio_in_i[0] -> ISR reads 0x0001 3 edges later, int_o=1 one cycle after; write ISR=0x0001 -> ISR=0, int_o=0.
REQ-031 EDGE=0x0004, pin 2 rising then falling -> only falling sets ISR[2]; IER=0 keeps int_o=0 while ISR[2]=1.
REQ-032 W1C on ISR[5] in same cycle as new rising event on pin 5 -> ISR[5] stays 1.
REQ-033 Read index 8 (addr 0x20) -> rdata=0, rresp=2'b10; write index 8 -> bresp=2'b10, no register changes.
REQ-034 AW valid two cycles before W valid, bready held low 3 cycles -> single handshake when both valid, bvalid held stable until bready; concurrent read served unaffected.
REQ-035 Assert reset_i with bvalid=1 and gpio_in_i=0xFFFF -> all outputs zero asynchronously; after release no ISR bits set, no stale B response.
